ib_dbuf: RTL

IB_DBUF -- requirements
Module: ib_dbuf

---
 rtl/ib_pkg.sv | 19 +
 rtl/ib_dbuf_if.sv | 39 +++
 rtl/ib_bank.sv | 51 +++++
 rtl/ib_dbuf.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ib_pkg.sv
//------------------------------------------------------------------
// ib_pkg: shared defaults and drain FSM encoding for ib_dbuf.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package ib_pkg;

  localparam int IB_WIDTH = 8;
  localparam int IB_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_st_e;

endpackage : ib_pkg

`default_nettype wire

// File: rtl/ib_dbuf_if.sv
//------------------------------------------------------------------
// ib_dbuf_if: write, parallel-vector and serial-drain signal bundle.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface ib_dbuf_if
  import ib_pkg::*;
#(
  parameter int WIDTH = IB_WIDTH,
  parameter int DEPTH = IB_DEPTH
) ();

  logic                   clr;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [WIDTH-1:0]       wr_data;
  logic                   vec_valid;
  logic [DEPTH*WIDTH-1:0] vec_data;
  logic                   vec_ack;
  logic                   rd_start;
  logic                   rd_valid;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_last;
  logic [1:0]             full_cnt;

  modport master (
    output clr, wr_valid, wr_data, vec_ack, rd_start,
    input  wr_ready, vec_valid, vec_data, rd_valid, rd_data, rd_last, full_cnt
  );

  modport slave (
    input  clr, wr_valid, wr_data, vec_ack, rd_start,
    output wr_ready, vec_valid, vec_data, rd_valid, rd_data, rd_last, full_cnt
  );

endinterface : ib_dbuf_if

`default_nettype wire

// File: rtl/ib_bank.sv
//------------------------------------------------------------------
// ib_bank: one DEPTH x WIDTH register bank with full flag and flat view.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module ib_bank
  import ib_pkg::*;
#(
  parameter int WIDTH = IB_WIDTH,
  parameter int DEPTH = IB_DEPTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   clr_i,
  input  wire logic                   we_i,
  input  wire logic [IW-1:0]          idx_i,
  input  wire logic [WIDTH-1:0]       data_i,
  input  wire logic                   rel_i,
  output      logic                   full_o,
  output      logic [DEPTH*WIDTH-1:0] vec_o
);

  localparam logic [IW-1:0] C_LAST = IW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        full_q;

  // Storage survives clr; only the full flag is control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= data_i;
        if (idx_i == C_LAST) full_q <= 1'b1;
      end
      if (rel_i) full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign vec_o  = mem_q;

endmodule : ib_bank

`default_nettype wire

// File: rtl/ib_dbuf.sv
//------------------------------------------------------------------
// ib_dbuf: ping-pong vector buffer with parallel ack or serial drain.
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module ib_dbuf
  import ib_pkg::*;
#(
  parameter int WIDTH = IB_WIDTH,
  parameter int DEPTH = IB_DEPTH
) (
  input wire logic clk,
  input wire logic rst,
  ib_dbuf_if.slave bus
);

  localparam int            IW     = $clog2(DEPTH);
  localparam logic [IW-1:0] C_LAST = IW'(DEPTH - 1);

  drain_st_e        state_q, state_d;
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic                   w_full [2];
  logic [DEPTH*WIDTH-1:0] w_vec  [2];
  logic [1:0]             w_rel;
  logic                   w_wr_ready, w_wr_fire, w_vec_valid;
  logic [IW-1:0]          w_sel_idx;
  logic [WIDTH-1:0]       w_elem;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ib_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IW    (IW)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (bus.clr),
      .we_i   (w_wr_fire && (wb_q == 1'(b))),
      .idx_i  (wr_idx_q),
      .data_i (bus.wr_data),
      .rel_i  (w_rel[b]),
      .full_o (w_full[b]),
      .vec_o  (w_vec[b])
    );
  end

  assign w_wr_ready  = !w_full[wb_q];
  assign w_wr_fire   = bus.wr_valid && w_wr_ready;
  assign w_vec_valid = w_full[rb_q];
  assign w_sel_idx   = (state_q == ST_DRAIN) ? rd_idx_q : '0;

  always_comb begin
    w_elem = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_sel_idx == IW'(k)) w_elem = w_vec[rb_q][k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = '0;
    w_rel      = 2'b00;

    if (w_wr_fire) begin
      if (wr_idx_q == C_LAST) begin
        wr_idx_d = '0;
        wb_d     = !wb_q;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Ack has priority over starting a drain of the same bank.
        if (w_vec_valid && bus.vec_ack) begin
          w_rel[rb_q] = 1'b1;
          rb_d        = !rb_q;
        end else if (w_vec_valid && bus.rd_start) begin
          state_d    = ST_DRAIN;
          rd_valid_d = 1'b1;
          rd_data_d  = w_elem;
          rd_idx_d   = IW'(1);
        end
      end
      ST_DRAIN: begin
        rd_valid_d = 1'b1;
        rd_data_d  = w_elem;
        if (rd_idx_q == C_LAST) begin
          rd_last_d   = 1'b1;
          w_rel[rb_q] = 1'b1;
          rb_d        = !rb_q;
          rd_idx_d    = '0;
          state_d     = ST_IDLE;
        end else begin
          rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clr) begin
      state_d    = ST_IDLE;
      wb_d       = 1'b0;
      rb_d       = 1'b0;
      wr_idx_d   = '0;
      rd_idx_d   = '0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = '0;
      w_rel      = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.wr_ready  = w_wr_ready;
  assign bus.vec_valid = w_vec_valid;
  assign bus.vec_data  = w_vec[rb_q];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.full_cnt  = {1'b0, w_full[0]} + {1'b0, w_full[1]};

endmodule : ib_dbuf

`default_nettype wire
